// File: rtl/pipelined_ripple_adder_pkg.sv
// -----------------------------------------------------------------------------
// pipelined_ripple_adder_pkg
//   Shared definitions for the pipelined ripple-carry add/subtract block.
//   - MODE_ADD / MODE_SUB : encoding of the 'sub' input.
//   - width_seg_ok()      : parameter legality check (SEG divides WIDTH and
//                           1 <= SEG <= WIDTH). It is evaluated at elaboration
//                           time by the top, which raises an error when the
//                           check fails.
// -----------------------------------------------------------------------------
package pipelined_ripple_adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic bit width_seg_ok(input int width, input int seg);
    return (seg >= 1) && (seg <= width) && ((width % seg) == 0);
  endfunction

endpackage

// File: rtl/pipelined_ripple_adder_rca.sv
// -----------------------------------------------------------------------------
// rca_segment
//   Purely combinational SEG-bit ripple-carry segment built on a
//   propagate/generate chain. It holds no state; every register of the
//   pipeline lives in pipelined_ripple_adder.
//
//   Ports:
//     a, b      [SEG-1:0]  operand slices (b is already inverted for subtract)
//     ci                   carry into bit 0 of the segment
//     s         [SEG-1:0]  sum slice
//     co                   carry out of the top bit of the segment
//     c_msb_in             carry into the top bit of the segment; XORed with
//                          co in the most significant segment gives signed
//                          overflow
// -----------------------------------------------------------------------------
module rca_segment
  import pipelined_ripple_adder_pkg::*;
#(
  parameter int SEG = 16
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           c_msb_in
);

  logic [SEG-1:0] p;
  logic [SEG-1:0] g;
  logic [SEG:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  // c[i] is the carry into bit i; c[SEG] is the segment carry-out.
  always_comb begin
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < SEG; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign s        = p ^ c[SEG-1:0];
  assign co       = c[SEG];
  assign c_msb_in = c[SEG-1];

endmodule

// File: rtl/pipelined_ripple_adder.sv
// -----------------------------------------------------------------------------
// pipelined_ripple_adder
//   WIDTH-bit add/subtract split into STAGES = WIDTH/SEG ripple segments, one
//   register stage per segment. The carry between segments is registered, the
//   operand slices of later segments are skewed (delayed) to meet their carry,
//   and the sum slices of earlier segments are deskewed so that the whole
//   result leaves the last stage together. Latency is STAGES cycles, one
//   beat per cycle throughput.
//
//   Ports:
//     clk, rst_n           clock (rising edge), async active-low reset
//     in_valid, in_ready   operand beat handshake
//     a, b   [WIDTH-1:0]   operands
//     cin                  carry-in (add mode only)
//     sub                  0: a+b+cin, 1: a-b (cin ignored)
//     out_valid, out_ready result beat handshake
//     sum    [WIDTH-1:0]   result, modulo 2^WIDTH
//     cout                 MSB carry-out; in subtract mode 1 means no borrow
//     ovf                  signed two's-complement overflow
//
//   Handshake: a beat transfers on a rising edge where valid && ready are
//   both high. The whole pipeline moves as one shift register: it advances
//   when the output slot is empty or being consumed
//   (advance = !out_valid || out_ready), and in_ready is exactly advance with
//   no dependency on in_valid. When advance is low every register, valids
//   included, holds, so the presented result stays stable. Bubbles
//   (in_valid low while advancing) flow through as valid=0 beats and are not
//   collapsed.
// -----------------------------------------------------------------------------
module pipelined_ripple_adder
  import pipelined_ripple_adder_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SEG   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG;
  localparam int LAST   = STAGES - 1;

  if (!width_seg_ok(WIDTH, SEG)) begin : g_bad_params
    $error("pipelined_ripple_adder: WIDTH must be a multiple of SEG with 1 <= SEG <= WIDTH");
  end

  logic              advance;
  logic [WIDTH-1:0]  b_eff;
  logic              c0;
  logic [STAGES-1:0] v_q;     // per-stage beat valid
  logic [STAGES-1:0] c_q;     // registered carry-out of each stage
  logic [STAGES-1:0] co_w;    // combinational carry-out of each segment
  logic              c_msb_last;
  logic              ovf_q;

  assign advance  = !v_q[LAST] || out_ready;
  assign in_ready = advance;

  // Subtract is a + ~b + 1; sub only matters for the beat it travels with,
  // because b_eff and c0 are consumed/registered at the input.
  assign b_eff = (sub == MODE_SUB) ? ~b : b;
  assign c0    = (sub == MODE_ADD) ? cin : 1'b1;

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    localparam int LO     = k * SEG;
    localparam int DESKEW = LAST - k;

    logic [SEG-1:0] a_seg;
    logic [SEG-1:0] b_seg;
    logic           ci_seg;
    logic [SEG-1:0] s_w;
    logic [SEG-1:0] s_q;

    if (k == 0) begin : g_head
      // Segment 0 works straight off the input port.
      assign a_seg  = a[LO +: SEG];
      assign b_seg  = b_eff[LO +: SEG];
      assign ci_seg = c0;
    end else begin : g_skew
      // Segment k sees its operand slices k cycles late, the same cycle the
      // carry from segment k-1 of that beat arrives in c_q[k-1].
      logic [SEG-1:0] a_sk [k];
      logic [SEG-1:0] b_sk [k];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < k; i++) begin
            a_sk[i] <= '0;
            b_sk[i] <= '0;
          end
        end else if (advance) begin
          a_sk[0] <= a[LO +: SEG];
          b_sk[0] <= b_eff[LO +: SEG];
          for (int i = 1; i < k; i++) begin
            a_sk[i] <= a_sk[i-1];
            b_sk[i] <= b_sk[i-1];
          end
        end
      end

      assign a_seg  = a_sk[k-1];
      assign b_seg  = b_sk[k-1];
      assign ci_seg = c_q[k-1];
    end

    if (k == LAST) begin : g_msb
      rca_segment #(.SEG(SEG)) u_rca (
        .a        (a_seg),
        .b        (b_seg),
        .ci       (ci_seg),
        .s        (s_w),
        .co       (co_w[k]),
        .c_msb_in (c_msb_last)
      );
    end else begin : g_mid
      // Only the most significant segment's top-bit carry feeds ovf.
      logic c_msb_unused;
      rca_segment #(.SEG(SEG)) u_rca (
        .a        (a_seg),
        .b        (b_seg),
        .ci       (ci_seg),
        .s        (s_w),
        .co       (co_w[k]),
        .c_msb_in (c_msb_unused)
      );
    end

    // Stage register for this segment's sum slice.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q <= '0;
      end else if (advance) begin
        s_q <= s_w;
      end
    end

    if (DESKEW == 0) begin : g_out
      assign sum[LO +: SEG] = s_q;
    end else begin : g_deskew
      // Hold the slice until the upper segments of the same beat catch up.
      logic [SEG-1:0] d_q [DESKEW];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DESKEW; i++) begin
            d_q[i] <= '0;
          end
        end else if (advance) begin
          d_q[0] <= s_q;
          for (int i = 1; i < DESKEW; i++) begin
            d_q[i] <= d_q[i-1];
          end
        end
      end

      assign sum[LO +: SEG] = d_q[DESKEW-1];
    end
  end

  // Beat valids and inter-stage carries. Valid never depends on operand
  // data, so unknown operands on idle cycles cannot reach out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
    end else if (advance) begin
      v_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        v_q[k] <= v_q[k-1];
      end
      c_q   <= co_w;
      ovf_q <= c_msb_last ^ co_w[LAST];
    end
  end

  assign out_valid = v_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_ripple_adder
//   Four DUT configurations (64/16, 8/1, 16/4, 32/32) share one clock. Each
//   has its own driver (operand beats, resets), a reference model computed
//   with plain wide arithmetic, an expected queue, and a monitor that owns
//   out_ready and checks every delivered result, latency, hold-while-stalled
//   and the in_ready relation.
// -----------------------------------------------------------------------------
module tb_pipelined_ripple_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic int cfg_width(input int i);
    case (i)
      0:       return 64;
      1:       return 8;
      2:       return 16;
      default: return 32;
    endcase
  endfunction

  function automatic int cfg_seg(input int i);
    case (i)
      0:       return 16;
      1:       return 1;
      2:       return 4;
      default: return 32;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int W  = cfg_width(g);
    localparam int S  = cfg_seg(g);
    localparam int ST = W / S;

    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    logic [W+1:0] exp_q[$];   // {sum, cout, ovf}
    int           t_q[$];     // cycle count at acceptance
    int           cyc       = 0;
    int           bp_mode   = 0;  // 0: always ready, 1: 1,0,0 pattern, 2: random
    int           rst_count = 0;
    bit           done      = 1'b0;

    pipelined_ripple_adder #(.WIDTH(W), .SEG(S)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: unsigned sum/difference for sum and cout, signed range
    // test for ovf.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mc, input logic ms);
      logic [W:0]   full;
      logic [W+1:0] sa, sb, sr;
      logic [W-1:0] s;
      logic         co, ov;
      sa = {{2{ma[W-1]}}, ma};
      sb = {{2{mb[W-1]}}, mb};
      if (ms) begin
        s  = ma - mb;
        co = (ma >= mb);
        sr = sa - sb;
      end else begin
        full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
        s    = full[W-1:0];
        co   = full[W];
        sr   = sa + sb + {{(W+1){1'b0}}, mc};
      end
      ov = !((sr[W+1:W-1] == 3'b000) || (sr[W+1:W-1] == 3'b111));
      return {s, co, ov};
    endfunction

    function automatic logic [W-1:0] rand_operand();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      case ($urandom_range(0, 7))
        0: r = '1;
        1: r = '0;
        2: begin r = '1; r = r >> (65 - W); end
        3: r = 64'd1 << (W - 1);
        default: ;
      endcase
      return r[W-1:0];
    endfunction

    task automatic idle(input int n);
      repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic drive_beat(input logic [W-1:0] ta, input logic [W-1:0] tb,
                              input logic tc, input logic ts);
      int  guard;
      bit  ok;
      guard = 0;
      ok    = 1'b0;
      a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
      while (!ok && guard < 200) begin
        @(posedge clk);
        if (in_ready) ok = 1'b1;
        else guard++;
      end
      if (ok) begin
        exp_q.push_back(model(ta, tb, tc, ts));
        t_q.push_back(cyc);
      end else begin
        checks++;
        errors++;
        $display("FAIL cfg%0d accept_timeout: in_ready=%b required 1 within 200 cycles", g, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      a = 'x; b = 'x; cin = 1'bx; sub = 1'bx;
    endtask

    task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL cfg%0d drain: %0d results outstanding, required 0", g, exp_q.size());
      end
      idle(2);
    endtask

    initial begin : drv
      logic [W-1:0] ones;
      logic [W-1:0] half;
      ones = '1;
      half = ones >> (W / 2);
      rst_n = 1'b0; in_valid = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL cfg%0d reset_state: ov=%b sum=%h cout=%b ovf=%b ir=%b required 0,0,0,0,1",
                 g, out_valid, sum, cout, ovf, in_ready);
      end
      rst_n = 1'b1;
      @(negedge clk);

      // Directed corner cases.
      bp_mode = 0;
      drive_beat(half, W'(1), 1'b0, 1'b0);
      idle(2);
      drive_beat(ones, '0, 1'b1, 1'b0);
      idle(1);
      drive_beat(ones >> 1, W'(1), 1'b0, 1'b0);
      drive_beat(W'(5), W'(7), 1'b1, 1'b1);
      drive_beat(W'(7), W'(5), 1'b0, 1'b1);
      drain();

      // 20 back-to-back beats against 1,0,0 backpressure.
      bp_mode = 1;
      repeat (20) drive_beat(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)),
                             1'($urandom_range(0, 1)));
      drain();

      // Reset with three beats in flight.
      bp_mode = 0;
      repeat (3) drive_beat(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)));
      #2;
      rst_n = 1'b0;
      rst_count++;
      #1;
      checks++;
      if (out_valid !== 1'b0 || sum !== '0) begin
        errors++;
        $display("FAIL cfg%0d async_reset: out_valid=%b sum=%h required 0 and 0", g, out_valid, sum);
      end
      exp_q.delete();
      t_q.delete();
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      drive_beat(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drain();

      // Random sweep: latency-checked first, then random backpressure.
      for (int i = 0; i < 1000; i++) begin
        if (i == 300) begin
          drain();
          bp_mode = 2;
        end
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        drive_beat(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
      end
      drain();
      done = 1'b1;
    end

    initial begin : mon
      bit           held_v;
      logic [W+1:0] held;
      logic [W+1:0] e;
      int           t;
      int           pat;
      int           seen_rst;
      held_v   = 1'b0;
      held     = '0;
      pat      = 0;
      seen_rst = 0;
      out_ready = 1'b1;
      forever begin
        @(negedge clk);
        case (bp_mode)
          0:       out_ready = 1'b1;
          1:       begin out_ready = (pat % 3 == 0); pat++; end
          default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
        #1;
        if (seen_rst != rst_count) begin
          seen_rst = rst_count;
          held_v   = 1'b0;
        end
        checks++;
        if (in_ready !== (!out_valid || out_ready)) begin
          errors++;
          $display("FAIL cfg%0d in_ready: got %b required %b", g, in_ready, !out_valid || out_ready);
        end
        if (held_v) begin
          checks++;
          if (out_valid !== 1'b1 || {sum, cout, ovf} !== held) begin
            errors++;
            $display("FAIL cfg%0d hold: out_valid=%b value=%h required 1 and %h",
                     g, out_valid, {sum, cout, ovf}, held);
          end
        end
        held_v = out_valid && !out_ready;
        held   = {sum, cout, ovf};
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL cfg%0d unexpected_beat: sum=%h with no result outstanding", g, sum);
          end else begin
            e = exp_q.pop_front();
            t = t_q.pop_front();
            if ({sum, cout, ovf} !== e) begin
              errors++;
              $display("FAIL cfg%0d result: got sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                       g, sum, cout, ovf, e[W+1:2], e[1], e[0]);
            end
            if (bp_mode == 0) begin
              checks++;
              if (cyc - t != ST) begin
                errors++;
                $display("FAIL cfg%0d latency: got %0d required %0d", g, cyc - t, ST);
              end
            end
          end
        end
      end
    end
  end

  initial begin : report
    bit all_done;
    all_done = 1'b0;
    for (int k = 0; k < 60000 && !all_done; k++) begin
      @(negedge clk);
      all_done = g_cfg[0].done && g_cfg[1].done && g_cfg[2].done && g_cfg[3].done;
    end
    if (!all_done) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: stimulus incomplete after 60000 cycles, required completion");
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_ripple_adder.md
Name: pipelined_ripple_adder

Overview:
Parametrised, pipelined successor to the single-cycle ripple-carry adder. The WIDTH-bit add/subtract is split into SEG-bit ripple segments, with one register stage per segment; the carry is registered between stages. A valid/ready handshake with backpressure lets it sit between streaming datapath blocks and close timing at large WIDTH.

Parameters:
WIDTH, 64, operand/sum width in bits; must be a multiple of SEG.
SEG, 16, bits per ripple segment (one pipeline stage each); 1 <= SEG <= WIDTH.
STAGES, WIDTH/SEG, derived localparam (not overridable); pipeline depth.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand beat valid.
in_ready  output  1  block accepts a beat this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in; used in add mode only.
sub  input  1  0 = a+b+cin, 1 = a-b (cin ignored).
out_valid  output  1  result beat valid.
out_ready  input  1  downstream accepts result.
sum  output  WIDTH  result.
cout  output  1  carry-out of MSB; in sub mode, 1 = no borrow (a >= b unsigned).
ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset (rst_n low, async): all stage valid bits, carries, skew and deskew registers cleared. out_valid=0, sum=0, cout=0, ovf=0. A reset asserted mid-operation discards all in-flight beats; no partial result is ever presented.
- Operand prep at input: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin. sub is captured with the beat.
- Stage k (0..STAGES-1) adds bits [k*SEG +: SEG] of a and b_eff using the registered carry from stage k-1 (c0 for k=0). It registers the SEG-bit partial sum and the carry-out.
- Skew: operand slices for segment k travel through k delay registers alongside the beat. Deskew: the sum slice from segment k travels through STAGES-1-k registers so all slices emerge together.
- ovf = carry_into_MSB XOR carry_out_of_MSB, computed in the last stage.
- Latency: STAGES cycles from accepted beat (in_valid && in_ready at edge N) to out_valid at edge N+STAGES, when there is no backpressure. Throughput is 1 beat/cycle.
- Handshake:
  - advance = !out_valid || out_ready.
  - in_ready = advance (combinational; no dependency on in_valid).
  - When advance=0, every pipeline register, including valids, holds.
  - Bubbles are not collapsed.
- Output stability: while out_valid && !out_ready, sum/cout/ovf hold.
- Arithmetic wraps modulo 2^WIDTH. For example, add with all-ones + 1 gives sum=0, cout=1.
- Simultaneous events: input accept and output consume in the same cycle are both legal. If in_valid=0 while advancing, a bubble (valid=0) enters stage 0.
- SEG=WIDTH degenerates to a single registered stage, latency 1.
- X on a/b/cin/sub while in_valid=0 must not propagate to out_valid.

Decomposition:
- Shared package: the add/sub mode encoding constants (MODE_ADD=0, MODE_SUB=1) and the legality check for WIDTH % SEG == 0. Elaboration fails via a generate-time error when the check is violated.
- Sub-module rca_segment: combinational SEG-bit ripple-carry segment with a p/g chain.
  - Inputs: a, b, ci. Outputs: s, co, c_msb_in (carry into the top bit, used for ovf).
  - Instantiated STAGES times inside a generate loop.
  - All registers live in pipelined_ripple_adder.

Test Plan:
- Default params, add: a=64'h0000_0000_FFFF_FFFF, b=1, cin=0. Expect exactly 4 cycles later sum=64'h0000_0001_0000_0000, cout=0, ovf=0 (carry crosses stage boundaries).
- Wrap/overflow: a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=1 gives sum=0, cout=1, ovf=0. Then a=64'h7FFF_FFFF_FFFF_FFFF, b=1, cin=0 gives sum=64'h8000_0000_0000_0000, cout=0, ovf=1.
- Subtract: sub=1, a=5, b=7, cin=1 (ignored). Expect sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. Then a=7, b=5 gives sum=2, cout=1.
- Streaming with backpressure:
  - Stimulus: 20 back-to-back random beats; out_ready toggles 1,0,0,1,...
  - Expected: in_ready == (!out_valid || out_ready) every cycle; results in order, none lost or duplicated, all matching a reference model; sum held stable while stalled.
- Reset mid-flight: accept 3 beats, then pulse rst_n low for a partial cycle (asynchronous). Expect out_valid=0 and sum=0 immediately, and no stale result afterwards. The next beat after release appears with latency 4.
- Param sweep: (WIDTH,SEG) = (8,1), (16,4), (32,32). Run 1000 random add/sub beats each. Expect latency = WIDTH/SEG and results equal to the model.
